// File: rtl/recv_contest_sld_if.sv
// rtl/recv_contest_sld_if.sv - serial line in, RAM write port and status out for recv_contest_sld
interface recv_contest_sld_if #(
  parameter int ADDR_W = 16
);
  logic              rxd;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [7:0]        wd;
  logic [31:0]       byte_count;
  logic              busy;
  logic              frame_err;
  logic              done;

  // master is the host/line side, slave is the receiver
  modport master (
    output rxd,
    input  we, wa, wd, byte_count, busy, frame_err, done
  );

  modport slave (
    input  rxd,
    output we, wa, wd, byte_count, busy, frame_err, done
  );
endinterface

// File: rtl/recv_contest_sld.sv
// rtl/recv_contest_sld.sv - 8N1 UART receiver writing each good byte to consecutive RAM addresses
// Optional end-of-stream done pulse built only when RECV_TIMEOUT_EN is defined.
module recv_contest_sld #(
  parameter int CLK_PER_HALF_BIT = 435,
  parameter int ADDR_W           = 16,
  parameter int IDLE_CYCLES      = 100000
) (
  input  logic               clk,
  input  logic               rst,
  recv_contest_sld_if.slave  bus
);

  localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int CNT_W   = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WRITE,
    S_WAITHIGH
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [7:0]        wd_q, wd_d;
  logic [31:0]       count_q, count_d;
  logic              ferr_q, ferr_d;

  logic              rxd_meta_q;
  logic              rxd_s_q;
  logic              rxd_prev_q;
  logic              fall;

  // Two-flop synchroniser; idle-high reset so no false start after rst
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= bus.rxd;
      rxd_s_q    <= rxd_meta_q;
      rxd_prev_q <= rxd_s_q;
    end
  end

  assign fall = rxd_prev_q & ~rxd_s_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      count_q <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      count_q <= count_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    count_d = count_q;
    ferr_d  = ferr_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = S_START;
        end
      end

      // Re-check the line at mid start bit to reject short glitches
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rxd_s_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rxd_s_q;
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      // Stop sample lands mid stop bit, so idle is back before the bit ends
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            state_d = S_WRITE;
            wd_d    = shreg_q;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAITHIGH;
          end
        end
      end

      S_WRITE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
        wa_d    = wa_q + 1'b1;
        if (count_q != 32'hFFFF_FFFF) begin
          count_d = count_q + 32'd1;
        end
      end

      S_WAITHIGH: begin
        cnt_d = '0;
        if (rxd_s_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.we         = (state_q == S_WRITE);
  assign bus.wa         = wa_q;
  assign bus.wd         = wd_q;
  assign bus.byte_count = count_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_err  = ferr_q;

`ifdef RECV_TIMEOUT_EN
  localparam int IDLE_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              wrote_q, wrote_d;
  logic              done_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
      wrote_q    <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      wrote_q    <= wrote_d;
    end
  end

  // Counter saturates at IDLE_LAST; wrote_q limits done to one pulse per burst
  assign done_now = (idle_cnt_q == IDLE_LAST) && wrote_q;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    wrote_d    = wrote_q;
    if (state_q == S_IDLE && fall) begin
      idle_cnt_d = '0;
    end else if (state_q == S_IDLE && rxd_s_q && idle_cnt_q != IDLE_LAST) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
    if (state_q == S_WRITE) begin
      wrote_d = 1'b1;
    end else if (done_now) begin
      wrote_d = 1'b0;
    end
  end

  assign bus.done = done_now;
`else
  assign bus.done = 1'b0;
`endif

endmodule

// File: tb/tb_recv_contest_sld.sv
// tb/tb_recv_contest_sld.sv - randomized self-checking bench for recv_contest_sld
module tb_recv_contest_sld;
  localparam int HALF = 4;
  localparam int AW   = 4;
  localparam int IDLE = 50;
  localparam int BITC = 2 * HALF;

  logic clk = 1'b0;
  logic rst = 1'b1;

  recv_contest_sld_if #(.ADDR_W(AW)) bus ();

  recv_contest_sld #(
    .CLK_PER_HALF_BIT(HALF),
    .ADDR_W(AW),
    .IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
    int            idx;
  } wr_t;

  wr_t           exp_q[$];
  int            wr_idx;
  logic          exp_ferr;
  int            n_vec;
  int            n_err;
  int            n_wr;
  int            done_cnt;
  logic          prev_we;
  logic [AW-1:0] last_wa;
  logic [7:0]    last_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : cmp
    wr_t e;
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (bus.we === 1'b1) begin
        chk("we_not_back_to_back", 32'(prev_we), 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 32'(bus.wa), 32'(e.addr));
          chk("write_data", 32'(bus.wd), 32'(e.data));
          chk("count_at_write", bus.byte_count, 32'(e.idx));
        end
        last_wa = bus.wa;
        last_wd = bus.wd;
        n_wr++;
      end
      if (bus.done === 1'b1) done_cnt++;
      prev_we = bus.we;
    end
  end

  task automatic hold(input logic v, input int n);
    bus.rxd = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.rxd = 1'b1;
    rst     = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst      = 1'b0;
    exp_q.delete();
    wr_idx   = 0;
    exp_ferr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back('{addr: AW'(wr_idx), data: b, idx: wr_idx});
      wr_idx++;
    end else begin
      exp_ferr = 1'b1;
    end
    hold(1'b0, BITC);
    for (int i = 0; i < 8; i++) hold(b[i], BITC);
    hold(stop, BITC);
  endtask

  initial begin : watchdog
    #500000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n_before;
    int r;
    n_vec = 0; n_err = 0; n_wr = 0; done_cnt = 0;
    prev_we = 1'b0; last_wa = '0; last_wd = '0;
    bus.rxd = 1'b1;

    do_reset();
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_wa", 32'(bus.wa), 32'd0);
    chk("rst_wd", 32'(bus.wd), 32'd0);
    chk("rst_count", bus.byte_count, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ferr", 32'(bus.frame_err), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);

    // single byte
    send_frame(8'hA5, 1'b1);
    hold(1'b1, 12);
    chk("t1_pending", 32'(exp_q.size()), 32'd0);
    chk("t1_wd", 32'(last_wd), 32'hA5);
    chk("t1_wa", 32'(last_wa), 32'd0);
    chk("t1_count", bus.byte_count, 32'd1);
    chk("t1_ferr", 32'(bus.frame_err), 32'd0);
    chk("t1_wa_next", 32'(bus.wa), 32'd1);

    // back-to-back frames
    do_reset();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h3C, 1'b1);
    hold(1'b1, 12);
    chk("t2_pending", 32'(exp_q.size()), 32'd0);
    chk("t2_count", bus.byte_count, 32'd3);
    chk("t2_last_wa", 32'(last_wa), 32'd2);
    chk("t2_last_wd", 32'(last_wd), 32'h3C);

    // glitch
    n_before = n_wr;
    hold(1'b0, 2);
    hold(1'b1, 8);
    chk("t3_busy", 32'(bus.busy), 32'd0);
    chk("t3_no_write", 32'(n_wr), 32'(n_before));
    chk("t3_ferr", 32'(bus.frame_err), 32'd0);

    // bad stop bit, break, then a good byte
    do_reset();
    send_frame(8'h55, 1'b0);
    hold(1'b0, 40);
    hold(1'b1, 10);
    send_frame(8'h12, 1'b1);
    hold(1'b1, 12);
    chk("t4_ferr", 32'(bus.frame_err), 32'd1);
    chk("t4_count", bus.byte_count, 32'd1);
    chk("t4_wa", 32'(last_wa), 32'd0);
    chk("t4_wd", 32'(last_wd), 32'h12);
    chk("t4_pending", 32'(exp_q.size()), 32'd0);

    // address wrap, then reset mid-frame
    do_reset();
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1);
    hold(1'b1, 12);
    chk("t5_count", bus.byte_count, 32'd17);
    chk("t5_wa", 32'(last_wa), 32'd0);
    chk("t5_wd", 32'(last_wd), 32'h10);
    chk("t5_pending", 32'(exp_q.size()), 32'd0);
    n_before = n_wr;
    hold(1'b0, BITC);
    hold(1'b1, BITC);
    hold(1'b0, BITC);
    hold(1'b1, 4);
    do_reset();
    chk("t5_rst_wa", 32'(bus.wa), 32'd0);
    chk("t5_rst_count", bus.byte_count, 32'd0);
    chk("t5_rst_busy", 32'(bus.busy), 32'd0);
    hold(1'b1, 100);
    chk("t5_no_write", 32'(n_wr), 32'(n_before));

    // randomized mix of good bytes, bad stops and glitches
    do_reset();
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        send_frame(8'($urandom), 1'b1);
        hold(1'b1, $urandom_range(0, 12));
      end else if (r < 8) begin
        send_frame(8'($urandom), 1'b0);
        hold(1'b0, $urandom_range(0, 40));
        hold(1'b1, $urandom_range(3, 10));
      end else begin
        hold(1'b0, $urandom_range(1, 3));
        hold(1'b1, 10);
      end
    end
    hold(1'b1, 20);
    chk("rnd_pending", 32'(exp_q.size()), 32'd0);
    chk("rnd_count", bus.byte_count, 32'(wr_idx));
    chk("rnd_ferr", 32'(bus.frame_err), 32'(exp_ferr));

`ifdef RECV_TIMEOUT_EN
    do_reset();
    done_cnt = 0;
    send_frame(8'h5A, 1'b1);
    hold(1'b1, 200);
    chk("t6_done_once", 32'(done_cnt), 32'd1);
    done_cnt = 0;
    hold(1'b1, 200);
    chk("t6_no_more_done", 32'(done_cnt), 32'd0);
`else
    chk("done_never", 32'(done_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/recv_contest_sld.md
Name: recv_contest_sld

Overview:
UART receiver (8N1, LSB first) that captures a byte stream from the host and writes each good byte into a byte-wide RAM write port at consecutive addresses. Used to load a program or data image over serial. It sits between the board rxd pin and a simple dual-port RAM, and is the receiving end of the serial sender used for the contest image.
- Bit timing is set by CLK_PER_HALF_BIT. The default gives 115200 bit/s.

Parameters:
- CLK_PER_HALF_BIT, 435, clock cycles per half UART bit; one full bit is 2*CLK_PER_HALF_BIT cycles.
- ADDR_W, 16, width of the RAM write address.
- IDLE_CYCLES, 100000, number of idle-high cycles after the last byte before done pulses (TIMEOUT_EN only).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rxd  in  1  asynchronous serial input; idles high
- we  out  1  RAM write strobe, one-cycle pulse per good byte
- wa  out  ADDR_W  RAM write address
- wd  out  8  RAM write data
- byte_count  out  32  number of good bytes written since reset
- busy  out  1  high from start-bit detect until return to idle
- frame_err  out  1  sticky; set on a bad stop bit
- done  out  1  one-cycle end-of-stream pulse (TIMEOUT_EN only)

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Input sync: rxd passes through 2 flops before any use (rxd_s). The sync flops reset to 1.
- Reset values: we=0, wa=0, wd=0, byte_count=0, busy=0, frame_err=0, done=0, state=S_IDLE. Reset asserted mid-frame aborts the frame with no write and does not change the address sequence beyond returning wa to 0.
- Bit counter: counts 0..2*CLK_PER_HALF_BIT-1, then restarts. Sample points fall at mid-bit.
- S_IDLE:
  - busy=0.
  - A 1->0 transition on rxd_s goes to S_START, sets busy=1 and clears the counter.
- S_START:
  - After CLK_PER_HALF_BIT-1 cycles, re-sample rxd_s.
  - If rxd_s=0, go to S_DATA with bit index 0 and clear the counter.
  - If rxd_s=1 (glitch), return to S_IDLE. No error is flagged and busy drops.
- S_DATA:
  - Every 2*CLK_PER_HALF_BIT cycles, shift rxd_s into bit[idx] (LSB first).
  - After bit 7, go to S_STOP.
- S_STOP: sample once after 2*CLK_PER_HALF_BIT cycles.
  - Sample = 1: go to S_WRITE.
  - Sample = 0: set frame_err, discard the byte and go to S_WAITHIGH.
- S_WRITE: lasts exactly one cycle.
  - we=1, wd=byte, wa=current address.
  - Next cycle: address+1 (wraps 2^ADDR_W-1 -> 0), byte_count+1 (saturates at 2^32-1).
  - Return to S_IDLE.
  - Latency: we is high the cycle after the stop-bit sample cycle.
- S_WAITHIGH: stay until rxd_s=1, then go to S_IDLE. A break condition (line held low) never causes a write.
- wa/wd hold their values between writes. we is never high for 2 consecutive cycles.
- Back-to-back frames: the falling edge of the next start bit may arrive any time after the stop-bit sample. Since idle is re-entered before the stop bit ends, no start bit is missed.
- frame_err is cleared only by rst.

Optional Feature:
Macro: RECV_TIMEOUT_EN.
- Defined:
  - An idle counter runs in S_IDLE while rxd_s=1. It is cleared on any start detect.
  - When the counter reaches IDLE_CYCLES and at least one byte has been written since the last done, done pulses for 1 cycle.
  - The written-since-done flag then clears, so done fires at most once per burst.
- Undefined: done is tied to 0, and no idle counter or flag is built.

Test Plan:
1. Setup: CLK_PER_HALF_BIT=4, ADDR_W=4.
   - Stimulus: send 0xA5 at 8 clk/bit.
   - Response: exactly one we pulse with wa=0, wd=0xA5. Afterwards byte_count=1, frame_err=0.
2. Back-to-back bytes.
   - Stimulus: send 0x00, 0xFF, 0x3C with no idle gap between frames.
   - Response: writes (wa,wd) = (0,0x00), (1,0xFF), (2,0x3C). byte_count=3.
3. Glitch on the line.
   - Stimulus: a 2-cycle low pulse on rxd.
   - Response: no we, busy returns to 0 within 6 cycles, frame_err=0.
4. Bad stop bit.
   - Stimulus: send 0x55 with stop bit 0, hold rxd low 40 cycles, then send 0x12.
   - Response: frame_err=1, the only write is (0,0x12), byte_count=1.
5. Address wrap and reset.
   - Stimulus: send 17 bytes 0x00..0x10, then assert rst in the middle of the data bits of an 18th byte.
   - Response before rst: 17th write has wa=0, wd=0x10, and byte_count=17.
   - Response after rst: wa=0, byte_count=0, and no write occurs for the aborted byte.
6. Timeout (RECV_TIMEOUT_EN, IDLE_CYCLES=50).
   - Stimulus: send 1 byte, then idle 200 cycles.
   - Response: done pulses once, 50 cycles into idle.
   - Follow-up: a further 200 idle cycles with no bytes produce no further done.
